// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding and the
// response bundle returned on the rsp_* channel.
package apb_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready and flags the cycle in
// which the count reaches TIMEOUT_CYCLES. Ports: pclk/presetn clock and
// async active-low reset; clear_i zeroes the count; en_i marks a wait
// cycle; expired_o is high in the wait cycle that would hit the limit.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = clear_i ^ en_i ^ pclk ^ presetn;
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] cnt_q;
            logic [W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != LAST)) begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // cnt_q already holds LAST earlier wait cycles, so this
            // wait cycle is the one that brings the total to the limit.
            assign expired_o = en_i && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one valid/ready command becomes one SETUP/ACCESS
// transfer; result returned on rsp_* (rdata, slverr, timeout).
// Ports: cmd_* command stream in, rsp_* response stream out,
// p* APB master signals. All outputs registered, reset to 0.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_mst_state_t        state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    apb_rsp_t              rsp_q, rsp_d;

    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;

    // Count restarts while in SETUP so ACCESS always begins at zero.
    assign tmr_clear = (state_q == SETUP);
    assign tmr_en    = (state_q == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .pclk     (pclk),
        .presetn  (presetn),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        unique case (state_q)
            IDLE: begin
                // cmd_ready comes up one edge after reset release.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready has priority over an expiring count.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = pwrite_q ? '0
                                  : APB_DATA_W'(prdata);
                    rsp_d.slverr  = pslverr;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (tmr_expired) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.slverr  = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_slverr  = rsp_q.slverr;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a small APB RAM slave
// whose wait states, error flag and ready behaviour are programmable.
module tb_apb_master_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
        int          lat;
    } exp_t;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int cur_lat = 0;
    int last_pop_cyc = 0;
    logic [4:0] exp_addr = '0;
    logic exp_write = 1'b0;
    logic rv_prev = 1'b0;
    exp_t exp_q[$];

    // slave model
    logic [31:0] mem [32];
    int  wait_states = 0;
    bit  never_ready = 1'b0;
    bit  err_mode = 1'b0;
    int  wcnt = 0;

    apb_master_bridge #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    assign pready = psel && penable && !never_ready
                    && (wcnt == wait_states);
    // garbage on prdata outside pready must be ignored by the bridge
    assign prdata  = pready ? mem[paddr] : 32'hDEAD_BEEF;
    assign pslverr = err_mode;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (psel && penable && pready && pwrite)
            mem[paddr] <= pwdata;
    end

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge pclk) begin
        if (rsp_valid && !rv_prev) cur_lat = cyc - accept_cyc;
        rv_prev = rsp_valid;
        if (psel && penable && pready) begin
            chk("paddr_hold", {58'd0, pwrite, paddr},
                {58'd0, exp_write, exp_addr});
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp", {30'd0, rsp_slverr, rsp_timeout, rsp_rdata},
                    {30'd0, e.slverr, e.timeout, e.rdata});
                if (e.lat >= 0)
                    chk("latency", 64'(cur_lat), 64'(e.lat));
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic issue(input logic w, input logic [4:0] a,
                         input logic [31:0] d, input bit push,
                         input logic [31:0] er, input logic es,
                         input logic et, input int lat);
        int n;
        exp_t e;
        if (push) begin
            e.rdata = er; e.slverr = es; e.timeout = et; e.lat = lat;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 40) begin
            chk("cmd_ready_wait", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        exp_addr  = a;
        exp_write = w;
        #1;
        accept_cyc = cyc;
        cmd_valid = 1'b0;
        chk("setup", {25'd0, psel, penable, pwrite, paddr,
                      (w ? pwdata : 32'd0)},
            {25'd0, 1'b1, 1'b0, w, a, (w ? d : 32'd0)});
        @(posedge pclk); #1;
        chk("access", {56'd0, psel, penable, paddr, 1'b0},
            {56'd0, 1'b1, 1'b1, a, 1'b0});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge pclk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge pclk); #1;
    endtask

    task automatic stall_check();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 20) chk("stall_rsp_wait", 64'd0, 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("stall_hold",
                {26'd0, rsp_valid, rsp_slverr, rsp_timeout,
                 cmd_ready, psel, penable, rsp_rdata},
                {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 32'h1234_5678});
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_outs",
            {cmd_ready, rsp_valid, psel, penable, pwrite, paddr,
             pwdata, rsp_rdata[20:0], rsp_slverr, rsp_timeout},
            64'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;
        chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        // zero-wait write then read back
        issue(1'b1, 5'd5, 32'h1234_5678, 1'b1,
              32'd0, 1'b0, 1'b0, 2);
        drain();
        issue(1'b0, 5'd5, 32'd0, 1'b1,
              32'h1234_5678, 1'b0, 1'b0, 2);
        drain();

        // 3 wait states, pslverr on read; pready lands on the
        // cycle the count would expire
        wait_states = 3;
        err_mode = 1'b1;
        issue(1'b0, 5'd5, 32'd0, 1'b1,
              32'h1234_5678, 1'b1, 1'b0, 5);
        drain();
        err_mode = 1'b0;
        issue(1'b1, 5'd9, 32'hA5A5_0F0F, 1'b1,
              32'd0, 1'b0, 1'b0, 5);
        drain();
        wait_states = 0;
        issue(1'b0, 5'd9, 32'd0, 1'b1,
              32'hA5A5_0F0F, 1'b0, 1'b0, 2);
        drain();

        // timeouts: slave never ready
        never_ready = 1'b1;
        issue(1'b0, 5'd2, 32'd0, 1'b1,
              32'd0, 1'b1, 1'b1, 5);
        drain();
        issue(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1,
              32'd0, 1'b1, 1'b1, 5);
        drain();
        never_ready = 1'b0;
        issue(1'b0, 5'd3, 32'd0, 1'b1,
              32'd0, 1'b0, 1'b0, 2);
        drain();

        // response back-pressure with a second command waiting
        rsp_ready = 1'b0;
        issue(1'b0, 5'd5, 32'd0, 1'b1,
              32'h1234_5678, 1'b0, 1'b0, 2);
        fork
            issue(1'b1, 5'd7, 32'hCAFE_F00D, 1'b1,
                  32'd0, 1'b0, 1'b0, 2);
            stall_check();
        join
        chk("second_after_hs", 64'(accept_cyc),
            64'(last_pop_cyc + 2));
        drain();
        issue(1'b0, 5'd7, 32'd0, 1'b1,
              32'hCAFE_F00D, 1'b0, 1'b0, 2);
        drain();

        // reset during ACCESS: no response, then normal operation
        never_ready = 1'b1;
        issue(1'b0, 5'd5, 32'd0, 1'b0,
              32'd0, 1'b0, 1'b0, -1);
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1;
        chk("async_reset",
            {60'd0, psel, penable, rsp_valid, cmd_ready}, 64'd0);
        @(negedge pclk); #1;
        presetn = 1'b1;
        never_ready = 1'b0;
        @(posedge pclk); #1;
        chk("ready_after_mid_reset", {63'd0, cmd_ready}, 64'd1);
        issue(1'b0, 5'd5, 32'd0, 1'b1,
              32'h1234_5678, 1'b0, 1'b0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
